// File: rtl/sobel_hls_deadlock_aggregator.sv
// rtl/sobel_hls_deadlock_aggregator.sv - persistence-filtered deadlock aggregator with one-shot report (optional SOBEL_DEADLOCK_TIMESTAMP_EN)
module sobel_hls_deadlock_aggregator #(
    parameter int NUM_MON        = 4,
    parameter int IDX_W          = 2,
    parameter int CONFIRM_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic [NUM_MON-1:0] mon_block,
    output logic               suspect,
    output logic               deadlock,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [NUM_MON-1:0] report_mask,
    output logic [31:0]        report_time
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUSPECT,
        ST_REPORT,
        ST_LATCHED
    } state_t;

    // A single sample is enough to confirm when CONFIRM_CYCLES is 1.
    localparam bit               DIRECT_CONFIRM = (CONFIRM_CYCLES == 1);
    // cnt holds the number of nonzero samples already seen in the episode, so
    // the edge that sees cnt == CONFIRM_CYCLES-1 is the confirming one.
    localparam logic [CNT_W-1:0] CONFIRM_LAST   = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX        = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               suspect_q, suspect_d;
    logic               deadlock_q, deadlock_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_MON-1:0] mask_q, mask_d;
    logic               any_block;
    logic               confirm;

    // Index of the lowest asserted monitor; scanning downward lets the lowest win.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_MON-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    assign any_block = |mon_block;

    // Episode tracking: next state, persistence count and report field updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        suspect_d  = 1'b0;
        deadlock_d = deadlock_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        confirm    = 1'b0;

        if (clear) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            deadlock_d = 1'b0;
            valid_d    = 1'b0;
            idx_d      = '0;
            mask_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_block) begin
                        idx_d  = lowest_idx(mon_block);
                        mask_d = mon_block;
                        cnt_d  = CNT_W'(1);
                        if (DIRECT_CONFIRM) begin
                            confirm = 1'b1;
                        end else begin
                            state_d   = ST_SUSPECT;
                            suspect_d = 1'b1;
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (!any_block) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        mask_d  = '0;
                    end else begin
                        // The blocking set may drift; only continuity matters.
                        mask_d = mask_q | mon_block;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (cnt_q >= CONFIRM_LAST) begin
                            confirm = 1'b1;
                        end else begin
                            suspect_d = 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    // valid_q is high throughout this state.
                    if (report_ready) begin
                        valid_d = 1'b0;
                        state_d = ST_LATCHED;
                    end
                end
                ST_LATCHED: begin
                    // Sticky until clear or reset.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (confirm) begin
                state_d    = ST_REPORT;
                deadlock_d = 1'b1;
                valid_d    = 1'b1;
            end
        end
    end

    // State and registered output bank.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            suspect_q  <= 1'b0;
            deadlock_q <= 1'b0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            suspect_q  <= suspect_d;
            deadlock_q <= deadlock_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
        end
    end

    assign suspect      = suspect_q;
    assign deadlock     = deadlock_q;
    assign report_valid = valid_q;
    assign report_idx   = idx_q;
    assign report_mask  = mask_q;

`ifdef SOBEL_DEADLOCK_TIMESTAMP_EN
    logic [31:0] tstamp_q;
    logic [31:0] time_q;

    // Free-running cycle stamp; deliberately untouched by clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            tstamp_q <= '0;
        end else begin
            tstamp_q <= tstamp_q + 32'd1;
        end
    end

    // Capture the pre-increment stamp on the confirming edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            time_q <= '0;
        end else if (clear) begin
            time_q <= '0;
        end else if (confirm) begin
            time_q <= tstamp_q;
        end
    end

    assign report_time = time_q;
`else
    assign report_time = 32'd0;
`endif

endmodule
